// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit (0), DATA_W data bits MSB-first, stop bit (1),
// each bit held for BIT_CYCLES clocks. Feeds the single-bit x input of the detector FSMs.
module serial_frame_tx #(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              x,
    output logic              frame,
    output logic              done,
    output logic [2:0]        currentState,
    output logic [2:0]        nextState
);

    localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        START = 3'b001,
        DATA  = 3'b010,
        STOP  = 3'b011,
        DONE  = 3'b100
    } state_t;

    // Plain vector so illegal codes 101..111 stay representable and recoverable.
    logic [2:0]        state_q, state_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              x_q, x_d;
    logic              frame_q, frame_d;
    logic              done_q, done_d;
    logic              last_cyc;

    assign last_cyc = (cyc_q == CYC_W'(BIT_CYCLES - 1));

    // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    state_d = START;
                    shift_d = load_data;
                    cyc_d   = '0;
                    bit_d   = '0;
                end
            end
            START: begin
                if (last_cyc) begin
                    state_d = DATA;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            DATA: begin
                if (last_cyc) begin
                    cyc_d   = '0;
                    shift_d = shift_q << 1;
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        state_d = STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            STOP: begin
                if (last_cyc) begin
                    state_d = DONE;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cyc_d   = '0;
                bit_d   = '0;
            end
        endcase

        // Outputs are derived from the next state so the registered copies line up with currentState.
        x_d = 1'b1;
        if (state_d == START) begin
            x_d = 1'b0;
        end else if (state_d == DATA) begin
            x_d = shift_d[DATA_W-1];
        end
        frame_d = (state_d == START) || (state_d == DATA) || (state_d == STOP);
        done_d  = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            x_q     <= 1'b1;
            frame_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            x_q     <= x_d;
            frame_q <= frame_d;
            done_q  <= done_d;
        end
    end

    assign load_ready   = (state_q == IDLE);
    assign x            = x_q;
    assign frame        = frame_q;
    assign done         = done_q;
    assign currentState = state_q;
    assign nextState    = state_d;

endmodule
